// File: rtl/multicycle_controller.sv
// Moore sequencer for the non-pipelined core: fetch, decode, execute, memory, writeback.
// Also holds the retired-instruction counter and a memory-ack watchdog that parks the core in FAULT.
module multicycle_controller #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             reg_write_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    if (XLEN < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_controller: XLEN and CNT_W must be at least 1");
    end

    localparam int unsigned WD_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned WD_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];
    localparam logic WD_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_expired_s;

    // Watchdog has run out when the cycle about to end is the last one allowed without an ack
    always_comb begin
        wd_expired_s = 1'b0;
        if (WD_EN) begin
            wd_expired_s = (wd_q == WD_LAST);
        end else begin
            wd_expired_s = 1'b0;
        end
    end

    // Next-state, retire counter and watchdog update
    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        wd_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack on the limit cycle still completes the fetch
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (wd_expired_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_FETCH;
                    wd_d    = wd_q + WD_W'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (dec_mem_read && dec_mem_write) begin
                    state_d = S_FAULT;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ack) begin
                    state_d = S_WRITEBACK;
                end else if (wd_expired_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_MEMORY;
                    wd_d    = wd_q + WD_W'(1);
                end
            end
            S_WRITEBACK: begin
                instret_d = instret_q + CNT_W'(1);
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State, retire counter and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            wd_q      <= wd_d;
        end
    end

    // Moore output decode; ir_load alone also looks at the fetch ack
    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_write     = 1'b0;
        reg_write_en = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
            end
            S_WRITEBACK: begin
                pc_write     = 1'b1;
                reg_write_en = dec_reg_write;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction reference model expands into expected per-cycle observations;
// a monitor pops and compares them against the controller outputs every cycle.
module tb_multicycle_controller;

    localparam int CNT_W = 4;
    localparam int T     = 4;
    localparam int MOD   = 1 << CNT_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DEC   = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_WB    = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;
    localparam logic [2:0] ST_FAULT = 3'd7;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BAD   = 3;

    typedef struct packed {
        logic [2:0]       st;
        logic             imem_req;
        logic             ir_load;
        logic             dmem_req;
        logic             dmem_we;
        logic             pc_write;
        logic             reg_write_en;
        logic             halted;
        logic             fault;
        logic [CNT_W-1:0] instret;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             imem_req, imem_ack, ir_load;
    logic             dmem_req, dmem_we, dmem_ack;
    logic             dec_mem_read, dec_mem_write, dec_reg_write, halt_req;
    logic             pc_write, reg_write_en, halted, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    obs_t exp_q[$];
    int   tests;
    int   fails;
    int   retired;
    bit   faulted;

    multicycle_controller #(
        .XLEN(32),
        .CNT_W(CNT_W),
        .MEM_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .ir_load(ir_load),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ack(dmem_ack),
        .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write),
        .halt_req(halt_req),
        .pc_write(pc_write),
        .reg_write_en(reg_write_en),
        .state(state),
        .halted(halted),
        .fault(fault),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected observation for one cycle spent in state st
    function automatic obs_t mk(input logic [2:0] st, input logic ia, input logic mwr, input logic rw);
        obs_t o;
        o.st           = st;
        o.imem_req     = (st == ST_FETCH);
        o.ir_load      = (st == ST_FETCH) && ia;
        o.dmem_req     = (st == ST_MEM);
        o.dmem_we      = (st == ST_MEM) && mwr;
        o.pc_write     = (st == ST_WB);
        o.reg_write_en = (st == ST_WB) && rw;
        o.halted       = (st == ST_HALT);
        o.fault        = (st == ST_FAULT);
        o.instret      = CNT_W'(retired % MOD);
        return o;
    endfunction

    task automatic cyc(input logic [2:0] st, input logic ia, input logic da, input logic mr,
                       input logic mwr, input logic rw, input logic hr);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        imem_ack      = ia;
        dmem_ack      = da;
        dec_mem_read  = mr;
        dec_mem_write = mwr;
        dec_reg_write = rw;
        halt_req      = hr;
        exp_q.push_back(mk(st, ia, mwr, rw));
    endtask

    task automatic rand_inputs();
        imem_ack      = rb();
        dmem_ack      = rb();
        dec_mem_read  = rb();
        dec_mem_write = rb();
        dec_reg_write = rb();
        halt_req      = rb();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_inputs();
        #1;
        tests++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || state !== ST_IDLE || instret !== '0) begin
            fails++;
            $display("FAIL async_reset: got st=%0d ireq=%b dreq=%b cnt=%0d, expected st=0 ireq=0 dreq=0 cnt=0",
                     state, imem_req, dmem_req, instret);
        end
        retired = 0;
        exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            rand_inputs();
            exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic do_halt(input int hold);
        for (int i = 0; i < hold; i++) cyc(ST_HALT, rb(), rb(), rb(), rb(), rb(), 1'b1);
        cyc(ST_HALT, rb(), rb(), rb(), rb(), rb(), 1'b0);
    endtask

    task automatic do_idle(input logic hlt, input int hold);
        cyc(ST_IDLE, rb(), rb(), rb(), rb(), rb(), hlt);
        if (hlt) do_halt(hold);
    endtask

    task automatic do_fault(input int n);
        for (int i = 0; i < n; i++) cyc(ST_FAULT, rb(), rb(), rb(), rb(), rb(), rb());
    endtask

    // One instruction: fw/mw are wait cycles before the ack; waits >= T time out
    task automatic do_instr(input int fw, input int kind, input int mw, input logic rw,
                            input logic hlt, input int hold, input bit abort_mem);
        logic mr, mwr;
        faulted = 1'b0;
        mr  = (kind == K_LOAD)  || (kind == K_BAD);
        mwr = (kind == K_STORE) || (kind == K_BAD);
        for (int i = 0; i < fw && i < T; i++) cyc(ST_FETCH, 1'b0, rb(), rb(), rb(), rb(), rb());
        if (fw >= T) begin
            faulted = 1'b1;
            return;
        end
        cyc(ST_FETCH, 1'b1, rb(), rb(), rb(), rb(), rb());
        cyc(ST_DEC, rb(), rb(), mr, mwr, rw, rb());
        cyc(ST_EXEC, rb(), rb(), mr, mwr, rw, rb());
        if (kind == K_BAD) begin
            faulted = 1'b1;
            return;
        end
        if (kind != K_ALU) begin
            for (int i = 0; i < mw && i < T; i++)
                cyc(ST_MEM, rb(), 1'b0, mr, mwr, rw, hlt ? 1'b1 : rb());
            if (abort_mem) return;
            if (mw >= T) begin
                faulted = 1'b1;
                return;
            end
            cyc(ST_MEM, rb(), 1'b1, mr, mwr, rw, hlt ? 1'b1 : rb());
        end
        cyc(ST_WB, rb(), rb(), mr, mwr, rw, hlt);
        retired++;
        if (hlt) do_halt(hold);
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 15) == 0) return T + int'($urandom_range(0, 1));
        return int'($urandom_range(0, T - 1));
    endfunction

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{state, imem_req, ir_load, dmem_req, dmem_we, pc_write, reg_write_en,
                      halted, fault, instret};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL cycle_obs @%0t: got st=%0d ireq=%b irl=%b dreq=%b dwe=%b pcw=%b rwe=%b hlt=%b flt=%b cnt=%0d, expected st=%0d ireq=%b irl=%b dreq=%b dwe=%b pcw=%b rwe=%b hlt=%b flt=%b cnt=%0d",
                             $time, a.st, a.imem_req, a.ir_load, a.dmem_req, a.dmem_we, a.pc_write,
                             a.reg_write_en, a.halted, a.fault, a.instret, e.st, e.imem_req, e.ir_load,
                             e.dmem_req, e.dmem_we, e.pc_write, e.reg_write_en, e.halted, e.fault, e.instret);
                end
            end
        end
    end

    // Driver: directed scenarios, then randomized instruction stream
    initial begin
        int kind, r;
        tests   = 0;
        fails   = 0;
        retired = 0;
        rst           = 1'b1;
        imem_ack      = 1'b0;
        dmem_ack      = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        halt_req      = 1'b0;

        do_reset(2);
        do_idle(1'b0, 0);
        do_instr(0, K_ALU, 0, 1'b1, 1'b0, 0, 1'b0);
        do_instr(0, K_LOAD, 3, 1'b1, 1'b0, 0, 1'b0);
        do_instr(0, K_STORE, 3, 1'b0, 1'b0, 0, 1'b0);
        do_instr(T - 1, K_ALU, 0, 1'b1, 1'b0, 0, 1'b0);
        do_instr(0, K_LOAD, 2, 1'b1, 1'b1, 2, 1'b0);
        do_instr(T, K_ALU, 0, 1'b1, 1'b0, 0, 1'b0);
        do_fault(20);
        do_reset(2);
        do_idle(1'b1, 1);
        do_instr(0, K_BAD, 0, 1'b1, 1'b0, 0, 1'b0);
        do_fault(3);
        do_reset(1);
        do_idle(1'b0, 0);
        do_instr(1, K_ALU, 0, 1'b1, 1'b0, 0, 1'b0);
        do_instr(0, K_STORE, T, 1'b0, 1'b0, 0, 1'b0);
        do_fault(2);
        do_reset(1);
        do_idle(1'b0, 0);
        do_instr(0, K_ALU, 0, 1'b0, 1'b0, 0, 1'b0);
        do_instr(0, K_LOAD, 2, 1'b1, 1'b0, 0, 1'b1);
        do_reset(2);
        do_idle(1'b0, 0);
        for (int i = 0; i < MOD + 1; i++) do_instr(0, K_ALU, 0, 1'b1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 19));
            if (r <= 8 || r >= 18)  kind = K_ALU;
            else if (r <= 12)       kind = K_LOAD;
            else if (r <= 16)       kind = K_STORE;
            else                    kind = K_BAD;
            do_instr(rand_wait(), kind, rand_wait(), rb(), ($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 3)), 1'b0);
            if (faulted) begin
                do_fault(int'($urandom_range(1, 4)));
                do_reset(int'($urandom_range(1, 2)));
                do_idle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            end
        end

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked observations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the single-issue, non-pipelined core through fetch, decode, execute, memory and writeback.
- Consumes the control flags produced by instruction decoding.
- Drives the instruction/data memory req/ack handshakes, IR load, PC update and register-file write enable.
- Keeps a retired-instruction counter and a memory-timeout watchdog that parks the core in a sticky FAULT state.

Parameters:
- XLEN, 32, datapath width; kept for consistency with the sibling blocks, no effect on logic here.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 255, maximum cycles waiting for an ack in FETCH or MEMORY; 0 disables the watchdog.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid; IR captures on this cycle.
- ir_load  out  1  IR capture strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (1) / read (0).
- dmem_ack  in  1  data access complete.
- dec_mem_read  in  1  decoded load.
- dec_mem_write  in  1  decoded store.
- dec_reg_write  in  1  decoded register-write intent.
- halt_req  in  1  level request to stop at the next instruction boundary.
- pc_write  out  1  PC update strobe (datapath selects sequential, branch or jump target).
- reg_write_en  out  1  register-file write enable; drives need_to_write.
- state  out  3  current state encoding.
- halted  out  1  1 in HALT.
- fault  out  1  1 in FAULT.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Reset (rst=0, asynchronous):
  - state=IDLE, instret=0, watchdog=0.
  - All strobes 0, halted=0, fault=0.
  - Reset mid-transaction drops the request immediately. A later ack is ignored.
- All outputs are decoded from the state register (Moore). imem_ack and dmem_ack act only through transitions.
  - Exception: ir_load = (state==FETCH) & imem_ack. It fires on the same cycle as the ack.
- IDLE:
  - go to HALT if halt_req, else to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1, go to DECODE.
  - Ack on the first FETCH cycle is legal, so a zero-wait fetch is 1 cycle.
- DECODE:
  - 1 cycle, always go to EXECUTE.
  - Decoded inputs must stay stable from DECODE through WRITEBACK; the IR holds them.
- EXECUTE:
  - 1 cycle.
  - dec_mem_read & dec_mem_write together: go to FAULT.
  - Exactly one of them set: go to MEMORY.
  - Neither set: go to WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_we=dec_mem_write.
  - On dmem_ack: go to WRITEBACK.
- WRITEBACK:
  - 1 cycle. reg_write_en=dec_reg_write, pc_write=1.
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state is HALT if halt_req, else FETCH.
- HALT:
  - halted=1, no requests issued.
  - Go to FETCH on the first cycle halt_req=0.
- FAULT:
  - fault=1, all strobes 0.
  - Sticky until rst.
- Watchdog:
  - Clears on entry to FETCH or MEMORY and counts each cycle without an ack.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with no ack: go to FAULT.
  - An ack in the same cycle as the limit wins; the transaction completes.
  - Counter width is clog2(MEM_TIMEOUT+1).
- Latency with zero-wait memory: ALU/branch/jump instruction 4 cycles, load/store 5 cycles.
- Stray acks outside FETCH/MEMORY are ignored.
- halt_req is sampled only in IDLE, WRITEBACK and HALT, so an in-flight instruction always retires.

Test Plan:
- Release rst, imem_ack tied 1, ALU instruction (dec_reg_write=1, no mem) → state sequence 0,1,2,3,5,1; reg_write_en and pc_write high exactly 1 cycle in 5; instret=1 after 5 cycles.
- Load with dmem_ack delayed 3 cycles → MEMORY lasts 4 cycles, dmem_we=0, reg_write_en=1 in WRITEBACK; store with same delay → dmem_we=1 throughout MEMORY, reg_write_en=0.
- MEM_TIMEOUT=4, imem_ack held 0 → FETCH 4 cycles then state=7, fault=1; fault persists 20 further cycles until rst=0.
- Ack asserted on the exact timeout cycle → DECODE entered, fault=0.
- dec_mem_read=dec_mem_write=1 → EXECUTE goes to FAULT; no dmem_req ever asserted.
- halt_req raised mid-MEMORY → instruction completes (instret+1), state=HALT, halted=1; halt_req dropped → FETCH next cycle.
- rst asserted during MEMORY with dmem_req=1 → dmem_req=0 asynchronously, instret=0; CNT_W=4, 16 retirements → instret wraps to 0.
